mips_bus_arbiter: RTL and testbench

// Sequences the single Avalon-MM master port of mips_cpu_bus for two requesters:

---
 rtl/mips_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// Single Avalon-MM master shared by instruction fetch and data load/store: arbitrates, drives
// registered bus outputs, replicates store lanes and aligns/extends load data.
module mips_bus_arbiter #(
    parameter bit          FETCH_PRIORITY = 1'b0,
    parameter int unsigned MAX_WAIT       = 0
) (
    input  logic        clk,
    input  logic        reset,
    // fetch requester
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    // status
    output logic        misaligned,
    output logic        timeout,
    output logic        busy,
    // Avalon-MM master
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StStore, StAck} state_e;

    state_e      state_q, state_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] writedata_q, writedata_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        misaligned_q, misaligned_d;
    logic        timeout_q, timeout_d;

    logic grant_fetch;
    logic if_bad;
    logic d_bad;
    logic wait_expired;

    function automatic logic [3:0] lane_enable(logic [1:0] size, logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(logic [1:0] size, logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{wdata[7:0]}};
            2'b01:   wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_align(logic [31:0] data, logic [1:0] lane,
                                               logic [1:0] size, logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (lane)
            2'd0: b = data[7:0];
            2'd1: b = data[15:8];
            2'd2: b = data[23:16];
            2'd3: b = data[31:24];
        endcase
        h = lane[1] ? data[31:16] : data[15:0];
        case (size)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    assign grant_fetch  = if_req && (!d_req || FETCH_PRIORITY);
    assign if_bad       = (if_addr[1:0] != 2'b00);
    assign d_bad        = (d_size == 2'b11) || (d_size == 2'b01 && d_addr[0])
                       || (d_size == 2'b10 && d_addr[1:0] != 2'b00);
    // Abort on the MAX_WAIT-th consecutive stalled cycle
    assign wait_expired = (MAX_WAIT != 0) && (wait_cnt_q + 32'd1 == MAX_WAIT);

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
        lane_d       = lane_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wait_cnt_d   = wait_cnt_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        misaligned_d = 1'b0;
        timeout_d    = timeout_q;

        unique case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (grant_fetch) begin
                    address_d = {if_addr[31:2], 2'b00};
                    lane_d    = if_addr[1:0];
                    size_d    = 2'b10;
                    uns_d     = 1'b0;
                    if (if_bad) begin
                        state_d      = StAck;
                        if_ack_d     = 1'b1;
                        misaligned_d = 1'b1;
                        if_rdata_d   = '0;
                    end else begin
                        state_d      = StFetch;
                        read_d       = 1'b1;
                        byteenable_d = 4'b1111;
                    end
                end else if (d_req) begin
                    address_d = {d_addr[31:2], 2'b00};
                    lane_d    = d_addr[1:0];
                    size_d    = d_size;
                    uns_d     = d_unsigned;
                    if (d_bad) begin
                        state_d      = StAck;
                        d_ack_d      = 1'b1;
                        misaligned_d = 1'b1;
                        d_rdata_d    = '0;
                    end else if (d_we) begin
                        state_d      = StStore;
                        write_d      = 1'b1;
                        byteenable_d = lane_enable(d_size, d_addr[1:0]);
                        writedata_d  = store_lanes(d_size, d_wdata);
                    end else begin
                        state_d      = StLoad;
                        read_d       = 1'b1;
                        byteenable_d = lane_enable(d_size, d_addr[1:0]);
                    end
                end
            end
            StFetch, StLoad, StStore: begin
                if (!waitrequest || wait_expired) begin
                    state_d    = StAck;
                    read_d     = 1'b0;
                    write_d    = 1'b0;
                    wait_cnt_d = '0;
                    if (state_q == StFetch) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = waitrequest ? '0 : readdata;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = (state_q == StLoad && !waitrequest)
                                  ? load_align(readdata, lane_q, size_q, uns_q) : '0;
                    end
                    if (waitrequest) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= '0;
            writedata_q  <= '0;
            lane_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wait_cnt_q   <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wait_cnt_q   <= wait_cnt_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = byteenable_q;
    assign writedata  = writedata_q;
    assign if_ack     = if_ack_q;
    assign d_ack      = d_ack_q;
    assign if_rdata   = if_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign misaligned = misaligned_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Randomized bench for mips_bus_arbiter: each transfer is predicted from the bus rules by a
// transaction-level model (lane arithmetic, cycle counts) and compared against the DUT.
module tb_mips_bus_arbiter;

    localparam int unsigned MaxWait = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, d_unsigned, waitrequest;
    logic [31:0] if_addr, d_addr, d_wdata, readdata;
    logic [1:0]  d_size;
    logic        if_ack, d_ack, misaligned, timeout, busy, read, write;
    logic [31:0] if_rdata, d_rdata, address, writedata;
    logic [3:0]  byteenable;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_timeout = 1'b0;

    mips_bus_arbiter #(
        .FETCH_PRIORITY(1'b0),
        .MAX_WAIT      (MaxWait)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .misaligned (misaligned),
        .timeout    (timeout),
        .busy       (busy),
        .address    (address),
        .read       (read),
        .write      (write),
        .waitrequest(waitrequest),
        .writedata  (writedata),
        .byteenable (byteenable),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_misaligned(bit fetch, logic [31:0] a, logic [1:0] size);
        int unsigned off;
        off = a % 4;
        if (fetch) return off != 0;
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return (off % 2) != 0;
            2'd2:    return off != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] model_be(bit fetch, logic [31:0] a, logic [1:0] size);
        int unsigned n;
        if (fetch || size == 2'd2) return 4'hF;
        n = (size == 2'd0) ? 1 : 3;
        return 4'(n << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(logic [1:0] size, logic [31:0] w);
        if (size == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] rd, logic [31:0] a,
                                               logic [1:0] size, bit uns);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Starts with the DUT idle, #1 after a rising edge; returns in the same condition.
    task automatic do_txn(input string name, input bit fetch, input bit we, input logic [31:0] a,
                          input logic [1:0] size, input bit uns, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd);
        bit          mis, tmo, store;
        int          exp_bus, bus_n, ack_cyc;
        logic [31:0] exp_rdata;
        mis     = model_misaligned(fetch, a, size);
        tmo     = !mis && (waits >= int'(MaxWait));
        store   = !fetch && we;
        exp_bus = mis ? 0 : (tmo ? int'(MaxWait) : waits + 1);
        if (mis || tmo || store) exp_rdata = '0;
        else if (fetch)          exp_rdata = rd;
        else                     exp_rdata = model_load(rd, a, size, uns);
        bus_n   = 0;
        ack_cyc = 0;
        readdata    = rd;
        waitrequest = 1'b0;
        if (fetch) begin
            if_req  = 1'b1;
            if_addr = a;
        end else begin
            d_req      = 1'b1;
            d_we       = we;
            d_addr     = a;
            d_size     = size;
            d_unsigned = uns;
            d_wdata    = wd;
        end
        for (int c = 1; c <= 40 && ack_cyc == 0; c++) begin
            @(posedge clk);
            #1;
            check_val({name, " busy"}, busy, 1);
            if (read || write) begin
                bus_n++;
                check_val({name, " rw"}, {read, write}, store ? 2'b01 : 2'b10);
                check_val({name, " addr"}, address, a & 32'hFFFFFFFC);
                check_val({name, " be"}, byteenable, model_be(fetch, a, size));
                if (store) check_val({name, " wdata"}, writedata, model_wdata(size, wd));
                waitrequest = (bus_n <= waits);
            end
            if (if_ack || d_ack) begin
                ack_cyc = c;
                check_val({name, " ack_sel"}, {if_ack, d_ack}, fetch ? 2'b10 : 2'b01);
                check_val({name, " rdata"}, fetch ? if_rdata : d_rdata, exp_rdata);
                check_val({name, " misaligned"}, misaligned, mis);
            end
        end
        check_val({name, " ack_cycle"}, ack_cyc, exp_bus + 1);
        check_val({name, " bus_cycles"}, bus_n, exp_bus);
        if (tmo) exp_timeout = 1'b1;
        check_val({name, " timeout"}, timeout, exp_timeout);
        if_req      = 1'b0;
        d_req       = 1'b0;
        waitrequest = 1'b0;
        @(posedge clk);
        #1;
        check_val({name, " idle"}, {busy, if_ack, d_ack, read, write}, 0);
    endtask

    initial begin
        bit          f, we, uns;
        logic [31:0] a, wd, rd;
        logic [1:0]  sz;
        int          waits, d_at, if_at, acks;

        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_unsigned = 1'b0; waitrequest = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; readdata = '0; d_size = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset bus", {read, write, byteenable}, 0);
        check_val("reset address", address, 0);
        check_val("reset writedata", writedata, 0);
        check_val("reset rdata", if_rdata | d_rdata, 0);
        check_val("reset status", {busy, timeout, misaligned, if_ack, d_ack}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_txn("fetch", 1'b1, 1'b0, 32'h0000_0400, 2'd2, 1'b0, '0, 0, 32'h8C02_0004);
        do_txn("lb_s", 1'b0, 1'b0, 32'h0000_1003, 2'd0, 1'b0, '0, 0, 32'h80FF_FFFF);
        do_txn("lb_u", 1'b0, 1'b0, 32'h0000_1003, 2'd0, 1'b1, '0, 0, 32'h80FF_FFFF);
        do_txn("sh", 1'b0, 1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h1234_ABCD, 4, '0);
        do_txn("lw_mis", 1'b0, 1'b0, 32'h0000_3001, 2'd2, 1'b0, '0, 0, 32'hDEAD_BEEF);

        for (int i = 0; i < 40; i++) begin
            f   = ($urandom_range(0, 3) == 0);
            we  = $urandom_range(0, 1) != 0;
            uns = $urandom_range(0, 1) != 0;
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f || sz == 2'd2) a[1:0] = 2'b00;
                else if (sz == 2'd1) a[0] = 1'b0;
            end
            waits = $urandom_range(0, 5);
            do_txn("rnd", f, we, a, sz, uns, wd, waits, rd);
        end

        // Simultaneous requests: data wins, fetch follows after the data ack.
        readdata = 32'hCAFE_F00D;
        waitrequest = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0500;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600; d_size = 2'd2; d_unsigned = 1'b0;
        d_at = 0;
        if_at = 0;
        for (int c = 1; c <= 20 && if_at == 0; c++) begin
            @(posedge clk);
            #1;
            if (read) check_val("arb addr", address, (d_at == 0) ? 32'h600 : 32'h500);
            check_val("arb both_ack", {if_ack, d_ack} == 2'b11, 0);
            if (d_ack) begin
                d_at  = c;
                d_req = 1'b0;
                check_val("arb d_rdata", d_rdata, 32'hCAFE_F00D);
            end
            if (if_ack) begin
                if_at  = c;
                if_req = 1'b0;
                check_val("arb if_rdata", if_rdata, 32'hCAFE_F00D);
            end
        end
        check_val("arb d_ack_cycle", d_at, 2);
        check_val("arb if_ack_cycle", if_at, 5);
        @(posedge clk);
        #1;

        do_txn("tmo", 1'b0, 1'b0, 32'h0000_4000, 2'd2, 1'b0, '0, 20, 32'h1111_2222);

        // Reset mid-transfer drops the access with no ack.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5000; d_size = 2'd2;
        waitrequest = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val("rst pre_read", read, 1);
        reset = 1'b1;
        #1;
        check_val("rst read", read, 0);
        check_val("rst busy", busy, 0);
        check_val("rst timeout", timeout, 0);
        check_val("rst address", address, 0);
        d_req = 1'b0;
        waitrequest = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        acks = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (if_ack || d_ack || read || write) acks++;
        end
        check_val("rst no_ack", acks, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
